// File: rtl/wave_ram_arbiter_if.sv
// Bus bundle for wave_ram_arbiter: capture-side writes, display-side reads,
// the single-port RAM connection and the drop statistic.
interface wave_ram_arbiter_if;
    logic        wr_req;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [8:0]  rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [15:0] drop_count;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
        input  rd_ack, rd_valid, rd_data, ram_addr, ram_we, ram_wdata, drop_count
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
        output rd_ack, rd_valid, rd_data, ram_addr, ram_we, ram_wdata, drop_count
    );
endinterface

// File: rtl/wave_ram_arbiter.sv
// Arbitrates a never-stalled capture write stream and a display read port onto one 512x8 RAM.
// Optional drop statistic enabled by macro WAVE_RAM_ARBITER_STATS_EN.
module wave_ram_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    wave_ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_WRITE = 2'd1,
        SLOT_READ  = 2'd2
    } slot_e;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    slot_e       slot_s;
    logic        rd_ack_s;
    logic [16:0] in_s;
    logic [16:0] fifo0_r, fifo1_r, fifo0_s, fifo1_s;
    logic [1:0]  fifo_cnt_r, fifo_cnt_s;
    logic [3:0]  wait_r, wait_s;
    logic [8:0]  ram_addr_r, ram_addr_s;
    logic        ram_we_r, ram_we_s;
    logic [7:0]  ram_wdata_r, ram_wdata_s;
    logic        rd_pend_r;
    logic        rd_valid_r;

    assign in_s     = {bus.wr_addr, bus.wr_data};
    assign rd_ack_s = (slot_s == SLOT_READ);

    // Slot choice: a starved read beats writes, writes beat ordinary reads.
    always_comb begin
        slot_s = SLOT_IDLE;
        if (bus.rd_req && (wait_r == WAIT_LIMIT)) begin
            slot_s = SLOT_READ;
        end else if ((fifo_cnt_r != 2'd0) || bus.wr_req) begin
            slot_s = SLOT_WRITE;
        end else if (bus.rd_req) begin
            slot_s = SLOT_READ;
        end else begin
            slot_s = SLOT_IDLE;
        end
    end

    // Next FIFO contents, RAM command and read-starvation counter.
    always_comb begin
        fifo0_s     = fifo0_r;
        fifo1_s     = fifo1_r;
        fifo_cnt_s  = fifo_cnt_r;
        ram_addr_s  = 9'd0;
        ram_we_s    = 1'b0;
        ram_wdata_s = 8'd0;
        case (slot_s)
            SLOT_WRITE: begin
                ram_we_s = 1'b1;
                if (fifo_cnt_r == 2'd0) begin
                    {ram_addr_s, ram_wdata_s} = in_s;
                end else begin
                    // Head leaves; entry 0 is always the oldest queued write.
                    {ram_addr_s, ram_wdata_s} = fifo0_r;
                    if (bus.wr_req) begin
                        if (fifo_cnt_r == 2'd1) begin
                            fifo0_s = in_s;
                        end else begin
                            fifo0_s = fifo1_r;
                            fifo1_s = in_s;
                        end
                    end else begin
                        fifo0_s    = fifo1_r;
                        fifo_cnt_s = fifo_cnt_r - 2'd1;
                    end
                end
            end
            SLOT_READ: begin
                ram_addr_s = bus.rd_addr;
                if (bus.wr_req) begin
                    if (fifo_cnt_r == 2'd0) begin
                        fifo0_s    = in_s;
                        fifo_cnt_s = 2'd1;
                    end else if (fifo_cnt_r == 2'd1) begin
                        fifo1_s    = in_s;
                        fifo_cnt_s = 2'd2;
                    end else begin
                        fifo_cnt_s = fifo_cnt_r;
                    end
                end else begin
                    fifo_cnt_s = fifo_cnt_r;
                end
            end
            default: begin
                ram_addr_s = 9'd0;
            end
        endcase

        wait_s = wait_r;
        if (!bus.rd_req || rd_ack_s) begin
            wait_s = 4'd0;
        end else if (wait_r == WAIT_LIMIT) begin
            wait_s = wait_r;
        end else begin
            wait_s = wait_r + 4'd1;
        end
    end

    // State, registered RAM controls and the two-stage read-return pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo0_r     <= 17'd0;
            fifo1_r     <= 17'd0;
            fifo_cnt_r  <= 2'd0;
            wait_r      <= 4'd0;
            ram_addr_r  <= 9'd0;
            ram_we_r    <= 1'b0;
            ram_wdata_r <= 8'd0;
            rd_pend_r   <= 1'b0;
            rd_valid_r  <= 1'b0;
        end else begin
            fifo0_r     <= fifo0_s;
            fifo1_r     <= fifo1_s;
            fifo_cnt_r  <= fifo_cnt_s;
            wait_r      <= wait_s;
            ram_addr_r  <= ram_addr_s;
            ram_we_r    <= ram_we_s;
            ram_wdata_r <= ram_wdata_s;
            rd_pend_r   <= rd_ack_s;
            rd_valid_r  <= rd_pend_r;
        end
    end

    // rd_ack is combinational, so it is gated by reset to stay quiet while reset is held.
    assign bus.rd_ack    = rd_ack_s & reset_n;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = rd_valid_r ? bus.ram_rdata : 8'd0;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_we    = ram_we_r;
    assign bus.ram_wdata = ram_wdata_r;

`ifdef WAVE_RAM_ARBITER_STATS_EN
    logic        drop_s;
    logic [15:0] drop_cnt_r;

    assign drop_s = (slot_s == SLOT_READ) && bus.wr_req && (fifo_cnt_r == 2'd2);

    // Saturating count of writes lost to a full queue during a read slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign bus.drop_count = drop_cnt_r;
`else
    assign bus.drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Self-checking bench: two arbiters (MAX_WAIT=4 and MAX_WAIT=1) share one input stream and
// are compared every cycle against a behavioural model, plus directed literal checks.
module tb_wave_ram_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

`ifdef WAVE_RAM_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    wave_ram_arbiter_if bus0 ();
    wave_ram_arbiter_if bus1 ();

    wave_ram_arbiter #(.MAX_WAIT(4)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    wave_ram_arbiter #(.MAX_WAIT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    assign bus1.wr_req  = bus0.wr_req;
    assign bus1.wr_addr = bus0.wr_addr;
    assign bus1.wr_data = bus0.wr_data;
    assign bus1.rd_req  = bus0.rd_req;
    assign bus1.rd_addr = bus0.rd_addr;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a) ^ 8'hA5;
    endfunction

    // Registered-read RAMs, one per arbiter.
    logic [7:0] ram0 [512];
    logic [7:0] ram1 [512];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 512; a++) begin
                ram0[a] <= init_val(a);
                ram1[a] <= init_val(a);
            end
            bus0.ram_rdata <= 8'd0;
            bus1.ram_rdata <= 8'd0;
            mem_ready      <= 1'b1;
        end else begin
            if (bus0.ram_we) ram0[bus0.ram_addr] <= bus0.ram_wdata;
            if (bus1.ram_we) ram1[bus1.ram_addr] <= bus1.ram_wdata;
            bus0.ram_rdata <= ram0[bus0.ram_addr];
            bus1.ram_rdata <= ram1[bus1.ram_addr];
        end
    end

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h time=%0t", name, inst, act, exp, $time);
        end
    endtask

    // Behavioural model state, indexed by arbiter instance.
    logic [16:0] mq [2][2];
    int          mq_n [2];
    int          wt [2];
    int          drops [2];
    logic [8:0]  e_addr [2];
    logic        e_we [2];
    logic [7:0]  e_wdata [2];
    logic        p1 [2];
    logic [7:0]  p1d [2];
    logic        vv [2];
    logic [7:0]  vd [2];
    logic [7:0]  mmem [2][512];

    task automatic model_cycle(input int i, input logic a_ack, input logic a_valid, input logic [7:0] a_data,
                               input logic [8:0] a_addr, input logic a_we, input logic [7:0] a_wdata,
                               input logic [15:0] a_dc);
        int          slot;
        int          mw;
        int          dexp;
        logic [16:0] issue;
        logic [16:0] inw;
        mw   = (i == 0) ? 4 : 1;
        inw  = {bus0.wr_addr, bus0.wr_data};
        dexp = STATS ? ((drops[i] > 65535) ? 65535 : drops[i]) : 0;
        if (!reset_n) begin
            chk("reset_outputs", i, 64'({a_ack, a_valid, a_data, a_addr, a_we, a_wdata, a_dc}), 64'd0);
            mq_n[i] = 0; wt[i] = 0; drops[i] = 0;
            e_addr[i] = 9'd0; e_we[i] = 1'b0; e_wdata[i] = 8'd0;
            p1[i] = 1'b0; p1d[i] = 8'd0; vv[i] = 1'b0; vd[i] = 8'd0;
        end else begin
            if (bus0.rd_req && wt[i] == mw)          slot = 2;
            else if (mq_n[i] > 0 || bus0.wr_req)     slot = 1;
            else if (bus0.rd_req)                    slot = 2;
            else                                     slot = 0;
            chk("rd_ack", i, 64'(a_ack), 64'(slot == 2));
            chk("ram_addr", i, 64'(a_addr), 64'(e_addr[i]));
            chk("ram_we", i, 64'(a_we), 64'(e_we[i]));
            chk("ram_wdata", i, 64'(a_wdata), 64'(e_wdata[i]));
            chk("rd_valid", i, 64'(a_valid), 64'(vv[i]));
            chk("rd_data", i, 64'(a_data), 64'(vv[i] ? vd[i] : 8'd0));
            chk("drop_count", i, 64'(a_dc), 64'(dexp));
            // The write presented to the RAM this cycle is in memory before any later read samples it.
            if (e_we[i]) mmem[i][e_addr[i]] = e_wdata[i];
            vv[i]  = p1[i];
            vd[i]  = p1d[i];
            p1[i]  = (slot == 2);
            p1d[i] = mmem[i][bus0.rd_addr];
            case (slot)
                1: begin
                    if (mq_n[i] == 0) begin
                        issue = inw;
                    end else begin
                        issue    = mq[i][0];
                        mq[i][0] = mq[i][1];
                        mq_n[i]--;
                        if (bus0.wr_req) begin
                            mq[i][mq_n[i]] = inw;
                            mq_n[i]++;
                        end
                    end
                    e_addr[i] = issue[16:8]; e_we[i] = 1'b1; e_wdata[i] = issue[7:0];
                end
                2: begin
                    if (bus0.wr_req) begin
                        if (mq_n[i] < 2) begin
                            mq[i][mq_n[i]] = inw;
                            mq_n[i]++;
                        end else begin
                            drops[i]++;
                        end
                    end
                    e_addr[i] = bus0.rd_addr; e_we[i] = 1'b0; e_wdata[i] = 8'd0;
                end
                default: begin
                    e_addr[i] = 9'd0; e_we[i] = 1'b0; e_wdata[i] = 8'd0;
                end
            endcase
            if (!bus0.rd_req || slot == 2) wt[i] = 0;
            else if (wt[i] < mw)           wt[i]++;
        end
    endtask

    logic [16:0] wlog [$];
    int          we_run     = 0;
    int          we_run_max = 0;

    // Compare process: every falling edge, both arbiters against the model.
    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 512; a++) mmem[i][a] = init_val(a);
            mq_n[i] = 0; wt[i] = 0; drops[i] = 0;
            e_addr[i] = 9'd0; e_we[i] = 1'b0; e_wdata[i] = 8'd0;
            p1[i] = 1'b0; p1d[i] = 8'd0; vv[i] = 1'b0; vd[i] = 8'd0;
        end
        forever begin
            @(negedge clk);
            model_cycle(0, bus0.rd_ack, bus0.rd_valid, bus0.rd_data, bus0.ram_addr, bus0.ram_we,
                        bus0.ram_wdata, bus0.drop_count);
            model_cycle(1, bus1.rd_ack, bus1.rd_valid, bus1.rd_data, bus1.ram_addr, bus1.ram_we,
                        bus1.ram_wdata, bus1.drop_count);
            if (bus0.ram_we) begin
                wlog.push_back({bus0.ram_addr, bus0.ram_wdata});
                we_run++;
                if (we_run > we_run_max) we_run_max = we_run;
            end else begin
                we_run = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [8:0] wa, input logic [7:0] wd,
                         input logic r, input logic [8:0] ra);
        bus0.wr_req  = w;
        bus0.wr_addr = wa;
        bus0.wr_data = wd;
        bus0.rd_req  = r;
        bus0.rd_addr = ra;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog bench did not finish actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ack_at;
        int          cnt;
        int          last_ack;
        int          vbad;
        int          bad;
        logic        rd_hold;
        logic        r;
        logic [8:0]  ra;
        logic [16:0] expw;

        reset_n = 1'b0;
        drive(1'b0, 9'd0, 8'd0, 1'b0, 9'd0);

        // Reset held with random inputs: all outputs quiet.
        repeat (5) begin
            step();
            drive(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
        end
        probe();
        chk("t1_reset_zero", 0, 64'({bus0.rd_ack, bus0.rd_valid, bus0.rd_data, bus0.ram_addr,
                                     bus0.ram_we, bus0.ram_wdata, bus0.drop_count}), 64'd0);

        // First read after release: ack, address, data on consecutive cycles.
        step();
        reset_n = 1'b1;
        drive(1'b0, 9'd0, 8'd0, 1'b1, 9'h005);
        probe();
        chk("t1_ack_cycle0", 0, 64'(bus0.rd_ack), 64'd1);
        step();
        drive(1'b0, 9'd0, 8'd0, 1'b0, 9'd0);
        probe();
        chk("t1_ram_addr_cycle1", 0, 64'(bus0.ram_addr), 64'h005);
        chk("t1_ram_we_cycle1", 0, 64'(bus0.ram_we), 64'd0);
        step();
        probe();
        chk("t1_valid_cycle2", 0, 64'(bus0.rd_valid), 64'd1);
        chk("t1_data_cycle2", 0, 64'(bus0.rd_data), 64'hA0);

        // 256 back-to-back writes, no reads.
        step();
        wlog.delete();
        we_run_max = 0;
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, 9'(9'h100 + k), 8'(k) ^ 8'h3C, 1'b0, 9'd0);
            step();
        end
        drive(1'b0, 9'd0, 8'd0, 1'b0, 9'd0);
        repeat (3) step();
        probe();
        chk("t2_write_count", 0, 64'(wlog.size()), 64'd256);
        chk("t2_we_run", 0, 64'(we_run_max), 64'd256);
        bad = 0;
        if (wlog.size() == 256) begin
            for (int k = 0; k < 256; k++) begin
                expw = {9'(9'h100 + k), 8'(k) ^ 8'h3C};
                if (wlog[k] !== expw) bad++;
            end
            chk("t2_first", 0, 64'(wlog[0]), 64'({9'h100, 8'h3C}));
            chk("t2_last", 0, 64'(wlog[255]), 64'({9'h1FF, 8'hC3}));
        end
        chk("t2_order", 0, 64'(bad), 64'd0);

        // Continuous writes with one read: forced in the 5th cycle of the request.
        wlog.delete();
        ack_at   = -1;
        last_ack = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            drive(1'b1, 9'(9'h080 + k), 8'(k) ^ 8'h5A, (ack_at < 0), 9'h010);
            probe();
            if (ack_at < 0 && bus0.rd_ack) ack_at = k;
            if (bus0.rd_valid) last_ack = int'(bus0.rd_data);
        end
        step();
        drive(1'b0, 9'd0, 8'd0, 1'b0, 9'd0);
        repeat (4) step();
        probe();
        chk("t3_ack_cycle", 0, 64'(ack_at), 64'd4);
        chk("t3_read_data", 0, 64'(last_ack), 64'hB5);
        chk("t3_write_count", 0, 64'(wlog.size()), 64'd14);
        bad = 0;
        for (int k = 0; k < wlog.size() && k < 14; k++) begin
            expw = {9'(9'h080 + k), 8'(k) ^ 8'h5A};
            if (wlog[k] !== expw) bad++;
        end
        chk("t3_order", 0, 64'(bad), 64'd0);
        chk("t3_drop_count", 0, 64'(bus0.drop_count), 64'd0);

        // MAX_WAIT=1 arbiter: reads re-requested every cycle, FIFO fills, third read drops one write.
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            drive(1'b1, 9'(9'h020 + k), 8'(k), 1'b1, 9'h030);
            probe();
            if (bus1.rd_ack) cnt++;
        end
        step();
        drive(1'b0, 9'd0, 8'd0, 1'b0, 9'd0);
        repeat (4) step();
        probe();
        chk("t4_acks", 1, 64'(cnt), 64'd3);
        chk("t4_drop_count", 1, 64'(bus1.drop_count), STATS ? 64'd1 : 64'd0);
        chk("t4_drop_count_wait4", 0, 64'(bus0.drop_count), 64'd0);

        // Two writes queued, then reset one cycle after the read ack.
        wlog.delete();
        cnt      = 0;
        last_ack = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            drive(1'b1, 9'(9'h040 + k), 8'(k) ^ 8'hC3, 1'b1, 9'h044);
            probe();
            if (bus0.rd_ack) begin
                cnt++;
                last_ack = k;
            end
        end
        chk("t5_acks", 0, 64'(cnt), 64'd2);
        chk("t5_last_ack", 0, 64'(last_ack), 64'd9);
        step();
        reset_n = 1'b0;
        drive(1'b1, 9'h0C0, 8'h00, 1'b1, 9'h0C8);
        probe();
        vbad = int'(bus0.rd_valid);
        step();
        reset_n = 1'b1;
        wlog.delete();
        ack_at = -1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 9'(9'h0C0 + k), 8'(k), (ack_at < 0), 9'h0C8);
            probe();
            if (ack_at < 0 && bus0.rd_ack) ack_at = k;
            if (k < 6) vbad += int'(bus0.rd_valid);
            step();
        end
        drive(1'b0, 9'd0, 8'd0, 1'b0, 9'd0);
        repeat (4) step();
        probe();
        chk("t5_no_valid_after_reset", 0, 64'(vbad), 64'd0);
        chk("t5_wait_cleared_ack", 0, 64'(ack_at), 64'd4);
        bad = 0;
        foreach (wlog[k]) if (wlog[k][16:8] < 9'h0C0) bad++;
        chk("t5_queued_writes_discarded", 0, 64'(bad), 64'd0);
        chk("t5_write_count", 0, 64'(wlog.size()), 64'd8);

        // Random traffic with occasional reset pulses; the compare process checks every cycle.
        rd_hold = 1'b0;
        r       = 1'b0;
        ra      = 9'd0;
        for (int k = 0; k < 3000; k++) begin
            step();
            reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            if (!rd_hold) begin
                r  = ($urandom_range(0, 3) == 0);
                ra = 9'($urandom_range(0, 15));
            end
            drive(($urandom_range(0, 9) < 6), 9'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), r, ra);
            probe();
            rd_hold = reset_n && bus0.rd_req && !bus0.rd_ack;
        end
        step();
        reset_n = 1'b1;
        drive(1'b0, 9'd0, 8'd0, 1'b0, 9'd0);
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wave_ram_arbiter.md
WAVE_RAM_ARBITER -- requirements
Module: wave_ram_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive stalled cycles after which a pending read is forced ahead of writes (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port wr_req  input  1  capture-side write strobe; each high cycle is one write and is never stalled.
REQ-005 The block SHALL have port wr_addr  input  9  capture-side write address ({buffer bit, 8-bit sample index}).
REQ-006 The block SHALL have port wr_data  input  8  capture-side write sample.
REQ-007 The block SHALL have port rd_req  input  1  display-side read request; held high, with rd_addr stable, until rd_ack.
REQ-008 The block SHALL have port rd_addr  input  9  display-side read address.
REQ-009 The block SHALL have port rd_ack  output  1  single-cycle pulse: read granted this cycle.
REQ-010 The block SHALL have port rd_valid  output  1  single-cycle pulse: rd_data holds the granted read's result.
REQ-011 The block SHALL have port rd_data  output  8  read result; 0 when rd_valid is low.
REQ-012 The block SHALL have ports ram_addr output 9, ram_we output 1, ram_wdata output 8, ram_rdata input 8, connecting to a single-port 512x8 RAM with registered read (data in the cycle after the address).
REQ-013 The block SHALL have port drop_count  output  16  count of discarded writes (see REQ-031).

Function
REQ-014 The block SHALL, in each cycle, choose exactly one slot: WRITE, READ or IDLE.
REQ-015 The block SHALL hold a 2-entry write FIFO (addr+data) for writes that cannot be issued in their arrival cycle.
REQ-016 The block SHALL keep a wait counter: incremented each cycle rd_req=1 and rd_ack=0, saturating at MAX_WAIT, cleared to 0 on rd_ack or when rd_req=0.
REQ-017 The block SHALL select READ when rd_req=1 and the wait counter equals MAX_WAIT (forced read).
REQ-018 The block SHALL otherwise select WRITE when the FIFO is non-empty or wr_req=1.
REQ-019 The block SHALL otherwise select READ when rd_req=1, else IDLE.
REQ-020 The block SHALL, in a WRITE slot with an empty FIFO, issue the incoming write directly, storing nothing.
REQ-021 The block SHALL, in a WRITE slot with a non-empty FIFO, issue the FIFO head and push any incoming write to the tail, keeping write order.
REQ-022 The block SHALL, in a READ slot, push an incoming write to the FIFO if occupancy is below 2.
REQ-023 The block SHALL assert rd_ack combinationally in the cycle a READ slot is chosen.
REQ-024 The block SHALL register the RAM controls: a slot chosen in cycle N drives ram_addr/ram_we/ram_wdata in cycle N+1; ram_we=1 only for WRITE slots.
REQ-025 The block SHALL drive ram_addr=0, ram_we=0 and ram_wdata=0 in the cycle after an IDLE slot.
REQ-026 The block SHALL assert rd_valid in cycle N+2 for a read acked in cycle N, with rd_data=ram_rdata; read latency is 2 cycles.
REQ-027 The block SHALL NOT forward FIFO data to reads; a read of an address with a queued write returns the RAM contents.
REQ-028 The block SHALL accept a new rd_req in the cycle after rd_ack, so back-to-back reads issue every cycle when no writes are pending.

Reset
REQ-029 The block SHALL, while reset_n=0, clear the FIFO, the wait counter and drop_count, and drive rd_ack, rd_valid, rd_data, ram_addr, ram_we and ram_wdata to 0.
REQ-030 The block SHALL, on reset mid-operation, discard queued writes and suppress rd_valid for any in-flight read; the first slot decision is in the first cycle with reset_n=1.

Configuration
REQ-031 The block SHALL, with macro WAVE_RAM_ARBITER_STATS_EN defined, discard a write arriving in a READ slot with FIFO occupancy 2 and increment drop_count, saturating at 16'hFFFF.
REQ-032 The block SHALL, without WAVE_RAM_ARBITER_STATS_EN, tie drop_count to 0 and still discard the write in that case (REQ-022 unchanged).

Verification
REQ-033 Bench: reset_n=0 with random inputs -> every output 0; release, rd_req=1, rd_addr=9'h005, no writes -> rd_ack cycle 0, ram_addr=9'h005 cycle 1, rd_valid with rd_data=RAM[5] cycle 2.
REQ-034 Bench: wr_req=1 for 256 cycles with addr 9'h100..9'h1FF, no reads -> 256 RAM writes in order, ram_we high 256 consecutive cycles, FIFO never used.
REQ-035 Bench: continuous wr_req plus rd_req=1 at 9'h010, MAX_WAIT=4 -> rd_ack in 5th cycle of the request; the displaced write queues and all writes land in order; drop_count=0.
REQ-036 Bench: STATS_EN defined, continuous wr_req, three reads each re-requested the cycle after its rd_ack, MAX_WAIT=1 -> FIFO fills, third forced read drops one write, drop_count=1; without macro drop_count=0.
REQ-037 Bench: reset_n pulsed low one cycle after rd_ack with two writes queued -> no rd_valid, queued writes never reach RAM, wait counter 0 after release.
